// File: rtl/sha256_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_schedule_ctrl
//
// Message-schedule controller for the SHA-256 core. One 512-bit block arrives
// as 16 big-endian 32-bit words (W[0] first) and is held in a 16-entry
// circular word buffer. W[0..ROUNDS-1] is then emitted one word per output
// handshake. From t=16 onwards each new word is expanded in place:
//   W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]   (mod 2^32)
// and written back over slot t%16, which held W[t-16].
//
// Parameters:
//   ROUNDS     number of schedule words emitted per block (16..64)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort; back to idle LOAD, block discarded
//   in_valid   input word valid
//   in_ready   high in LOAD state only
//   in_word    message word
//   out_valid  high in RUN state only
//   out_ready  consumer accepts out_word
//   out_word   W[out_round]
//   out_round  index t of the current out_word
//   out_last   high with the final word of the block
//   busy       a block is partially loaded or being emitted
// ---------------------------------------------------------------------------
module sha256_schedule_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_round,
  output logic        out_last,
  output logic        busy
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  load_cnt;
  logic [5:0]  round;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] slot_mem [16];

  logic [3:0]  slot;
  logic [31:0] w_m16;
  logic [31:0] w_m15;
  logic [31:0] w_m7;
  logic [31:0] w_m2;
  logic [31:0] expanded;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Slot offsets are taken modulo 16 by the 4-bit adds: t-15 == t+1,
  // t-7 == t+9 and t-2 == t+14 in the circular buffer.
  assign slot     = round[3:0];
  assign w_m16    = slot_mem[slot];
  assign w_m15    = slot_mem[slot + 4'd1];
  assign w_m7     = slot_mem[slot + 4'd9];
  assign w_m2     = slot_mem[slot + 4'd14];
  assign expanded = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

  // The first 16 rounds just echo the loaded words.
  assign out_word  = (round < 6'd16) ? w_m16 : expanded;
  assign out_round = round;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (round == LAST_ROUND);
  assign busy      = (state != LOAD) || (load_cnt != 4'd0);

  // Control FSM and word buffer. flush outranks every handshake, so a
  // collision leaves round and the buffer untouched; stale buffer contents
  // after a flush are harmless because the next load overwrites all slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      load_cnt    <= 4'd0;
      round       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        slot_mem[i] <= 32'd0;
      end
    end else if (flush) begin
      state       <= LOAD;
      load_cnt    <= 4'd0;
      round       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready_q) begin
            slot_mem[load_cnt] <= in_word;
            load_cnt           <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state       <= RUN;
              round       <= 6'd0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (out_ready && out_valid_q) begin
            if (round >= 6'd16) begin
              slot_mem[slot] <= expanded;
            end
            if (round == LAST_ROUND) begin
              state       <= LOAD;
              round       <= 6'd0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              round <= round + 6'd1;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_schedule_ctrl
//
// Self-checking bench for sha256_schedule_ctrl. Each scenario task drives a
// block, collects the emitted schedule and compares it against a reference
// schedule computed directly from the SHA-256 expansion formula over a full
// 64-entry array. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sha256_schedule_ctrl;

  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [5:0]  out_round;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] blk      [16];
  logic [31:0] exp_w    [64];
  logic [31:0] got_word [64];
  logic [5:0]  got_round[64];
  logic        got_last [64];
  int          n_got;
  int          stall_err;
  int          coll_cycles;
  bit          coll_timeout;
  bit          drive_timeout;
  bit          adv_timeout;

  sha256_schedule_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_round(out_round),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside a bounded loop.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the SHA-256 definition.
  function automatic void build_model();
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        exp_w[t] = blk[t];
      end else begin
        s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
        s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
        exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
    end
  endfunction

  function automatic void random_block();
    for (int i = 0; i < 16; i++) begin
      blk[i] = $urandom;
    end
  endfunction

  // Feed blk[0..count-1]; gap_pct is the chance of an idle cycle.
  // Entered and left on a falling edge.
  task automatic applyStimulus_words(input int count, input int gap_pct);
    int accepted = 0;
    int cycles = 0;
    while (accepted < count && cycles < 1000) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_word  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_word  = blk[accepted];
      end
      if (in_valid && in_ready) accepted++;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    drive_timeout = (accepted < count);
  endtask

  // Consume one block's schedule with out_ready high ready_pct% of cycles,
  // recording every accepted word and counting value changes while stalled.
  task automatic collect_schedule(input int ready_pct);
    int cycles = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [31:0] held_w = 32'd0;
    logic [5:0]  held_r = 6'd0;
    n_got = 0;
    stall_err = 0;
    while (n_got < ROUNDS && cycles < 4000) begin
      if (out_valid) begin
        if (stalled && (out_word !== held_w || out_round !== held_r)) stall_err++;
        rdy = ($urandom_range(99) < ready_pct);
        out_ready = rdy;
        if (rdy) begin
          got_word[n_got]  = out_word;
          got_round[n_got] = out_round;
          got_last[n_got]  = out_last;
          n_got++;
        end
        stalled = !rdy;
        held_w  = out_word;
        held_r  = out_round;
      end else begin
        out_ready = 1'b0;
        stalled   = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
    coll_timeout = (n_got < ROUNDS);
    coll_cycles  = cycles;
  endtask

  // Hand-shake words until out_round reaches target; leaves out_ready high.
  task automatic advance_to(input int target);
    int cycles = 0;
    out_ready = 1'b1;
    while (out_round != 6'(target) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    adv_timeout = (out_round != 6'(target));
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_round, out_last, busy, out_word} !==
        {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rnd=%0d last=%b busy=%b word=%h, expected 1 0 0 0 0 00000000",
               in_ready, out_valid, out_round, out_last, busy, out_word);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_abc();
    $display("[TB] test_abc");
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
    applyStimulus_words(16, 0);
    n_checks++;
    if (drive_timeout || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abc_run_start: got timeout=%b vld=%b rdy=%b busy=%b, expected 0 1 0 1",
               drive_timeout, out_valid, in_ready, busy);
    end
    collect_schedule(100);
    n_checks++;
    if (coll_timeout || coll_cycles != ROUNDS) begin
      n_fail++;
      $display("FAIL abc_throughput: got %0d words in %0d cycles, expected %0d in %0d",
               n_got, coll_cycles, ROUNDS, ROUNDS);
    end
    n_checks++;
    if (got_word[16] !== 32'h61626380 || got_word[17] !== 32'h000F0000) begin
      n_fail++;
      $display("FAIL abc_w16_w17: got %h %h, expected 61626380 000f0000", got_word[16], got_word[17]);
    end
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i] || got_round[i] !== 6'(i) || got_last[i] !== (i == ROUNDS-1)) begin
        n_fail++;
        $display("FAIL abc_word[%0d]: got %h rnd=%0d last=%b, expected %h rnd=%0d last=%b",
                 i, got_word[i], got_round[i], got_last[i], exp_w[i], i, (i == ROUNDS-1));
      end
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_back_to_load: got rdy=%b vld=%b last=%b, expected 1 0 0",
               in_ready, out_valid, out_last);
    end
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    random_block();
    build_model();
    applyStimulus_words(16, 0);
    collect_schedule(30);
    n_checks++;
    if (drive_timeout || coll_timeout || stall_err != 0) begin
      n_fail++;
      $display("FAIL bp_stall: got timeout=%b/%b stall_changes=%0d, expected 0/0 0",
               drive_timeout, coll_timeout, stall_err);
    end
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i] || got_round[i] !== 6'(i) || got_last[i] !== (i == ROUNDS-1)) begin
        n_fail++;
        $display("FAIL bp_word[%0d]: got %h rnd=%0d last=%b, expected %h rnd=%0d last=%b",
                 i, got_word[i], got_round[i], got_last[i], exp_w[i], i, (i == ROUNDS-1));
      end
    end
  endtask

  task automatic test_gapped_input();
    $display("[TB] test_gapped_input");
    random_block();
    build_model();
    applyStimulus_words(16, 50);
    collect_schedule(100);
    n_checks++;
    if (drive_timeout || coll_timeout) begin
      n_fail++;
      $display("FAIL gap_timeout: got %b/%b, expected 0/0", drive_timeout, coll_timeout);
    end
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i] || got_round[i] !== 6'(i)) begin
        n_fail++;
        $display("FAIL gap_word[%0d]: got %h rnd=%0d, expected %h rnd=%0d",
                 i, got_word[i], got_round[i], exp_w[i], i);
      end
    end
  endtask

  task automatic test_flush_load();
    $display("[TB] test_flush_load");
    random_block();
    applyStimulus_words(9, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_word  = blk[9];
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_load_idle: got busy=%b rdy=%b, expected 0 1", busy, in_ready);
    end
    random_block();
    build_model();
    applyStimulus_words(16, 0);
    n_checks++;
    if (drive_timeout || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_load_restart: got timeout=%b vld=%b, expected 0 1", drive_timeout, out_valid);
    end
    collect_schedule(100);
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL flush_load_word[%0d]: got %h, expected %h", i, got_word[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_flush_run();
    $display("[TB] test_flush_run");
    random_block();
    applyStimulus_words(16, 0);
    advance_to(40);
    out_ready = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (adv_timeout || out_valid !== 1'b0 || in_ready !== 1'b1 || out_round !== 6'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_run: got timeout=%b vld=%b rdy=%b rnd=%0d busy=%b, expected 0 0 1 0 0",
               adv_timeout, out_valid, in_ready, out_round, busy);
    end
  endtask

  task automatic test_flush_handshake();
    $display("[TB] test_flush_handshake");
    random_block();
    applyStimulus_words(16, 0);
    advance_to(20);
    flush = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (adv_timeout || out_round !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_hs: got timeout=%b rnd=%0d vld=%b rdy=%b, expected 0 0 0 1",
               adv_timeout, out_round, out_valid, in_ready);
    end
    random_block();
    build_model();
    applyStimulus_words(16, 0);
    collect_schedule(100);
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL flush_hs_word[%0d]: got %h, expected %h", i, got_word[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    $display("[TB] test_reset_mid_run");
    random_block();
    applyStimulus_words(16, 0);
    advance_to(30);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if (adv_timeout || {in_ready, out_valid, out_round, out_last, busy, out_word} !==
        {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: got timeout=%b rdy=%b vld=%b rnd=%0d last=%b busy=%b word=%h, expected 0 1 0 0 0 0 00000000",
               adv_timeout, in_ready, out_valid, out_round, out_last, busy, out_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    random_block();
    build_model();
    applyStimulus_words(16, 0);
    collect_schedule(100);
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i] || got_round[i] !== 6'(i)) begin
        n_fail++;
        $display("FAIL rst_run_word[%0d]: got %h rnd=%0d, expected %h rnd=%0d",
                 i, got_word[i], got_round[i], exp_w[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    random_block();
    build_model();
    applyStimulus_words(16, 0);
    collect_schedule(100);
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL b2b_a_word[%0d]: got %h, expected %h", i, got_word[i], exp_w[i]);
      end
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_bubble: got rdy=%b, expected 1", in_ready);
    end
    random_block();
    build_model();
    applyStimulus_words(16, 0);
    collect_schedule(100);
    n_checks++;
    if (drive_timeout || coll_timeout) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %b/%b, expected 0/0", drive_timeout, coll_timeout);
    end
    for (int i = 0; i < ROUNDS; i++) begin
      n_checks++;
      if (got_word[i] !== exp_w[i] || got_last[i] !== (i == ROUNDS-1)) begin
        n_fail++;
        $display("FAIL b2b_b_word[%0d]: got %h last=%b, expected %h last=%b",
                 i, got_word[i], got_last[i], exp_w[i], (i == ROUNDS-1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_gapped_input();
    test_flush_load();
    test_flush_run();
    test_flush_handshake();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_schedule_ctrl.md
Name: sha256_schedule_ctrl

Overview:
Message-schedule controller for the SHA-256 core. It accepts one 512-bit block as 16 sequential 32-bit words over a valid/ready input, keeps them in a 16-entry circular word buffer, and emits W[0..ROUNDS-1] one word per handshake to the compression round logic. For t>=16 it computes W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] in place, with 4-bit circular slot indexing. It sits between the padding/block-feed logic and the compression datapath.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns to IDLE, discards the block
in_valid  in  1  input word valid
in_ready  out  1  high in LOAD state only
in_word  in  32  message word, big-endian word order, W[0] first
out_valid  out  1  high in RUN state only
out_ready  in  1  consumer accepts out_word
out_word  out  32  W[round]
out_round  out  6  index t of the current out_word
out_last  out  1  out_valid && out_round==ROUNDS-1
busy  out  1  state != LOAD, or load_cnt != 0

Behaviour:
- States: LOAD, RUN. No separate idle state; LOAD with load_cnt==0 is idle.
- Reset (async, rst_n low) forces state=LOAD, load_cnt=0, round=0, and all buffer entries to 0. Outputs under reset: in_ready=1, out_valid=0, out_round=0, out_last=0, busy=0, out_word=0.
- LOAD:
  - in_ready=1. On each in_valid&&in_ready, buf[load_cnt] <= in_word and load_cnt increments.
  - On acceptance of the word with load_cnt==15: load_cnt wraps to 0, round <= 0, state <= RUN.
- RUN:
  - in_ready=0; out_valid=1 in the first cycle after the 16th word is accepted.
  - out_word is combinational from buffer and round: for t<16 it is buf[t]; for t>=16 it is the expansion result from slots (t)%16, (t-15)%16, (t-7)%16 and (t-2)%16.
  - Slot t%16 holds W[t-16] before the write.
  - Arithmetic is modulo 2^32; carries are dropped.
  - sigma0 = rotr7 ^ rotr18 ^ shr3; sigma1 = rotr17 ^ rotr19 ^ shr10.
- Output handshake at t>=16: buf[t%16] <= out_word and round increments. For t<16 the buffer is not written.
- out_word stays stable while out_valid && !out_ready. Backpressure of any length is legal.
- On the handshake with round==ROUNDS-1: state <= LOAD, round <= 0. in_ready rises in the next cycle, so there is one bubble between blocks. No input/output overlap.
- flush (synchronous, highest priority after reset) sets state=LOAD, load_cnt=0, round=0. The buffer contents are left as-is and are overwritten by the next load. A flush in the same cycle as a handshake wins: the handshake has no effect.
- in_valid during RUN is ignored (not accepted). out_ready during LOAD is ignored.
- Throughput: 16 load cycles plus ROUNDS output cycles per block with no backpressure.

Test Plan:
- Reset mid-RUN: assert rst_n=0 at round 30, then release -> in_ready=1, out_valid=0, out_round=0. A fresh block then produces a correct full schedule.
- "abc" block, no backpressure:
  - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - out_valid rises the cycle after W15 is accepted.
  - Required: W0..W15 echoed; W16=0x61626380; W17=0x000F0000.
  - All 64 words match the golden model; out_last is high only at out_round=63; in_ready rises the following cycle.
- Random backpressure (out_ready ~30% duty), random block -> out_word and out_round hold stable while stalled. The full sequence matches the golden model; no word is dropped or duplicated.
- Gapped input (in_valid toggling) -> exactly 16 words captured in order; the output sequence is identical to the gap-free case.
- flush:
  - During LOAD after 9 words -> the next 16 words form a fresh block.
  - During RUN at round 40 -> out_valid=0 the next cycle and in_ready=1.
  - flush together with an out handshake -> round is not advanced.
- Back-to-back blocks, ROUNDS=64 -> the second block's schedule is correct; there is no stale data from the first block's slots.
